// File: rtl/pulse_seq_ctrl.sv
// pulse_seq_ctrl: multi-channel transducer pulse sequencer.
// Each enabled channel runs TX -> DELAY -> ACQ -> HOLD with lengths latched at
// start; zero-length phases are skipped. ch_done/seq_done strobe in the cycle
// after a channel's final phase cycle, overlapping the next channel's first cycle.
// Optional macro PULSE_SEQ_LOOP_EN: repeat the sequence until abort or reset.
// state_dbg exposes the FSM state register for checkers.
module pulse_seq_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic [CNT_W-1:0]          tx_width,
    input  logic [CNT_W-1:0]          delay,
    input  logic [CNT_W-1:0]          win_len,
    input  logic [CNT_W-1:0]          holdoff,
    output logic                      busy,
    output logic                      tx_pulse,
    output logic                      acq_win,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      ch_done,
    output logic                      seq_done,
    output logic [2:0]                state_dbg
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TX    = 3'd1,
        DELAY = 3'd2,
        ACQ   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t             state, nxt_state, entry;
    logic [CNT_W-1:0]   cnt, nxt_cnt, cur_len;
    logic [CH_W-1:0]    nxt_ch;
    logic [CH_W:0]      found;
    logic               nxt_ch_done, nxt_seq_done, load_cfg;
    logic [NUM_CH-1:0]  mask_q;
    logic [CNT_W-1:0]   tx_q, dl_q, wl_q, hl_q;

    // First phase at or after position 'from' (1=TX..4=HOLD) with nonzero
    // length; IDLE means no phase remains for the current channel.
    function automatic state_t first_phase(input int from,
                                           input logic [CNT_W-1:0] t,
                                           input logic [CNT_W-1:0] d,
                                           input logic [CNT_W-1:0] w,
                                           input logic [CNT_W-1:0] h);
        state_t r;
        if (from <= 1 && t != '0)      r = TX;
        else if (from <= 2 && d != '0) r = DELAY;
        else if (from <= 3 && w != '0) r = ACQ;
        else if (from <= 4 && h != '0) r = HOLD;
        else                           r = IDLE;
        return r;
    endfunction

    // Lowest set mask bit above index 'after'; MSB of result is the found flag.
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m,
                                              input int after);
        logic [CH_W:0] r;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m[k] && k > after) r = {1'b1, CH_W'(k)};
        end
        return r;
    endfunction

    assign state_dbg = state;

    // Next-state, counter, channel and strobe decode.
    always_comb begin
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_ch       = ch_sel;
        nxt_ch_done  = 1'b0;
        nxt_seq_done = 1'b0;
        load_cfg     = 1'b0;
        entry        = IDLE;
        found        = '0;
        case (state)
            TX:      cur_len = tx_q;
            DELAY:   cur_len = dl_q;
            ACQ:     cur_len = wl_q;
            HOLD:    cur_len = hl_q;
            default: cur_len = '0;
        endcase

        if (state == IDLE) begin
            if (start && ch_mask != '0) begin
                load_cfg = 1'b1;
                found    = find_ch(ch_mask, -1);
                nxt_ch   = found[CH_W-1:0];
                entry    = first_phase(1, tx_width, delay, win_len, holdoff);
                if (entry == IDLE) begin
                    // Every phase is zero length: the sequence completes at once.
                    nxt_ch_done  = 1'b1;
                    nxt_seq_done = 1'b1;
                    nxt_ch       = '0;
                    nxt_cnt      = '0;
                end else begin
                    nxt_state = entry;
                    nxt_cnt   = CNT_W'(1);
                end
            end
        end else if (cnt == cur_len) begin
            entry = first_phase(int'(state) + 1, tx_q, dl_q, wl_q, hl_q);
            if (entry != IDLE) begin
                nxt_state = entry;
                nxt_cnt   = CNT_W'(1);
            end else begin
                // Channel complete; every channel starts at the same first phase.
                nxt_ch_done = 1'b1;
                entry       = first_phase(1, tx_q, dl_q, wl_q, hl_q);
                found       = find_ch(mask_q, int'(ch_sel));
                if (found[CH_W]) begin
                    nxt_ch    = found[CH_W-1:0];
                    nxt_state = entry;
                    nxt_cnt   = CNT_W'(1);
                end else begin
                    nxt_seq_done = 1'b1;
`ifdef PULSE_SEQ_LOOP_EN
                    found     = find_ch(mask_q, -1);
                    nxt_ch    = found[CH_W-1:0];
                    nxt_state = entry;
                    nxt_cnt   = CNT_W'(1);
`else
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                    nxt_ch    = '0;
`endif
                end
            end
        end else begin
            nxt_cnt = cnt + 1'b1;
        end

        // Abort wins over everything except reset, including a same-cycle start.
        if (abort) begin
            nxt_state    = IDLE;
            nxt_cnt      = '0;
            nxt_ch       = '0;
            nxt_ch_done  = 1'b0;
            nxt_seq_done = 1'b0;
            load_cfg     = 1'b0;
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ch_sel   <= '0;
            busy     <= 1'b0;
            tx_pulse <= 1'b0;
            acq_win  <= 1'b0;
            ch_done  <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            ch_sel   <= nxt_ch;
            busy     <= (nxt_state != IDLE);
            tx_pulse <= (nxt_state == TX);
            acq_win  <= (nxt_state == ACQ);
            ch_done  <= nxt_ch_done;
            seq_done <= nxt_seq_done;
        end
    end

    // Configuration captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q <= '0;
            tx_q   <= '0;
            dl_q   <= '0;
            wl_q   <= '0;
            hl_q   <= '0;
        end else if (load_cfg) begin
            mask_q <= ch_mask;
            tx_q   <= tx_width;
            dl_q   <= delay;
            wl_q   <= win_len;
            hl_q   <= holdoff;
        end
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Testbench for pulse_seq_ctrl (default build, loop mode off).
// Expected per-cycle outputs come from a timeline built directly from the
// channel mask and phase lengths.
module tb_pulse_seq_ctrl;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 14;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       ch_mask = '0;
    logic [CNT_W-1:0] tx_width = '0;
    logic [CNT_W-1:0] delay = '0;
    logic [CNT_W-1:0] win_len = '0;
    logic [CNT_W-1:0] holdoff = '0;
    logic             busy, tx_pulse, acq_win, ch_done, seq_done;
    logic [1:0]       ch_sel;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int seq_done_cyc;
    logic pend;
    // {busy, tx_pulse, acq_win, ch_done, seq_done, ch_sel}
    logic [6:0] exp_q[$];

    pulse_seq_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .ch_mask(ch_mask), .tx_width(tx_width), .delay(delay),
        .win_len(win_len), .holdoff(holdoff), .busy(busy),
        .tx_pulse(tx_pulse), .acq_win(acq_win), .ch_sel(ch_sel),
        .ch_done(ch_done), .seq_done(seq_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {busy, tx_pulse, acq_win, ch_done, seq_done, ch_sel};
    endfunction

    task automatic push_ent(input logic b, input logic t, input logic a, input logic [1:0] ch);
        exp_q.push_back({b, t, a, pend, 1'b0, ch});
        pend = 1'b0;
    endtask

    // Timeline: each enabled channel contributes tx/delay/win/hold cycles;
    // a channel's ch_done lands on the following cycle.
    task automatic build_model(input logic [3:0] m, input int t, input int d,
                               input int w, input int h);
        exp_q.delete();
        pend = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                for (int n = 0; n < t; n++) push_ent(1'b1, 1'b1, 1'b0, 2'(c));
                for (int n = 0; n < d; n++) push_ent(1'b1, 1'b0, 1'b0, 2'(c));
                for (int n = 0; n < w; n++) push_ent(1'b1, 1'b0, 1'b1, 2'(c));
                for (int n = 0; n < h; n++) push_ent(1'b1, 1'b0, 1'b0, 2'(c));
                pend = 1'b1;
            end
        end
        exp_q.push_back(7'b0001100);
        repeat (2) exp_q.push_back(7'b0000000);
    endtask

    // Runs one sequence; cut_at>0 aborts (or resets) after that cycle.
    task automatic run_seq(input logic [3:0] m, input int t, input int d,
                           input int w, input int h, input int cut_at,
                           input bit use_reset, input bit junk);
        build_model(m, t, d, w, h);
        @(negedge clk);
        ch_mask  = m;
        tx_width = CNT_W'(t);
        delay    = CNT_W'(d);
        win_len  = CNT_W'(w);
        holdoff  = CNT_W'(h);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seq_done_cyc = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL seq_cycle%0d mask=%b got %b want %b", i + 1, m, obs(), exp_q[i]);
            end
            if (seq_done === 1'b1 && seq_done_cyc < 0) seq_done_cyc = i + 1;
            if (cut_at == i + 1) begin
                if (use_reset) reset = 1'b0;
                else abort = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b1;
                abort = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (obs() !== 7'b0) begin
                        errors++;
                        $display("FAIL after_cut got %b want 0000000", obs());
                    end
                end
                checks++;
                if (state_dbg !== 3'd0) begin
                    errors++;
                    $display("FAIL cut_state got %0d want 0", state_dbg);
                end
                return;
            end
            if (junk && exp_q[i][6]) begin
                start    = 1'($urandom_range(0, 1));
                ch_mask  = 4'($urandom_range(0, 15));
                tx_width = CNT_W'($urandom_range(0, 7));
                delay    = CNT_W'($urandom_range(0, 7));
                win_len  = CNT_W'($urandom_range(0, 7));
                holdoff  = CNT_W'($urandom_range(0, 7));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        ch_mask = 4'b1111;
        tx_width = CNT_W'(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %b/%0d want 0000000/0", obs(), state_dbg);
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_release got %b want 0000000", obs());
        end
    endtask

    task automatic test_directed();
        run_seq(4'b0101, 3, 2, 5, 1, 0, 1'b0, 1'b0);
        checks++;
        if (seq_done_cyc != 23) begin
            errors++;
            $display("FAIL directed_seq_done_cycle got %0d want 23", seq_done_cyc);
        end
    endtask

    task automatic test_zero_mask();
        @(negedge clk);
        ch_mask = 4'b0000;
        tx_width = CNT_W'(3);
        win_len = CNT_W'(3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 7'b0) begin
                errors++;
                $display("FAIL zero_mask cycle%0d got %b want 0000000", i + 1, obs());
            end
        end
    endtask

    task automatic test_zero_phases();
        run_seq(4'b0001, 0, 0, 4, 0, 0, 1'b0, 1'b0);
        checks++;
        if (seq_done_cyc != 5) begin
            errors++;
            $display("FAIL zero_phase_seq_done_cycle got %0d want 5", seq_done_cyc);
        end
    endtask

    task automatic test_abort();
        run_seq(4'b0011, 1, 1, 6, 1, 14, 1'b0, 1'b0);
        // abort beats start in the same cycle
        @(negedge clk);
        ch_mask = 4'b0001;
        tx_width = CNT_W'(1);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0) begin
            errors++;
            $display("FAIL abort_over_start got %b want 0000000", obs());
        end
        run_seq(4'b0011, 1, 1, 6, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_seq(4'b1110, 2, 3, 4, 2, 15, 1'b1, 1'b0);
        run_seq(4'b1010, 1, 2, 3, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_seq(4'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 5), $urandom_range(0, 5), 0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_long_win();
        run_seq(4'b0001, 0, 0, 16383, 0, 0, 1'b0, 1'b0);
        checks++;
        if (seq_done_cyc != 16384) begin
            errors++;
            $display("FAIL long_win_seq_done_cycle got %0d want 16384", seq_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_mask();
        test_zero_phases();
        test_abort();
        test_reset_mid();
        test_random();
        test_long_win();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_seq_ctrl.md
PULSE_SEQ_CTRL -- requirements
Module: pulse_seq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of transducer channels sequenced (2..8).
REQ-002 Parameter CNT_W, default 14, width of all interval counters and interval inputs.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin one sequence.
REQ-006 abort  input  1  stop the sequence and return to idle.
REQ-007 ch_mask  input  NUM_CH  enabled channels; bit i set = channel i fires.
REQ-008 tx_width, delay, win_len, holdoff  input  CNT_W each  phase lengths in clk cycles.
REQ-009 busy  output  1  high while not IDLE.
REQ-010 tx_pulse  output  1  transmit trigger for the active channel.
REQ-011 acq_win  output  1  capture window gate for the active channel.
REQ-012 ch_sel  output  clog2(NUM_CH)  index of the active channel.
REQ-013 ch_done  output  1  one-cycle strobe at end of each channel's HOLD phase.
REQ-014 seq_done  output  1  one-cycle strobe when the last enabled channel completes.

Function
REQ-015 States IDLE, TX, DELAY, ACQ, HOLD; all outputs registered, decoded from state.
REQ-016 In IDLE, start=1 with ch_mask!=0 latches ch_mask, tx_width, delay, win_len, holdoff and selects the lowest set mask bit; TX entered next cycle.
REQ-017 start with ch_mask==0 ignored; start while busy ignored.
REQ-018 tx_pulse high exactly tx_width cycles in TX; acq_win high exactly win_len cycles in ACQ; DELAY lasts delay cycles; HOLD lasts holdoff cycles.
REQ-019 A phase whose latched length is 0 is skipped with zero cycles spent in it (tx_width=0: no tx_pulse for that channel).
REQ-020 Order per channel TX->DELAY->ACQ->HOLD; at HOLD end ch_done=1 for one cycle, then next higher set mask bit becomes ch_sel and TX entered the next cycle.
REQ-021 After the highest set mask bit, seq_done and ch_done both pulse on the same cycle and state returns to IDLE.
REQ-022 Counter is CNT_W bits, counts 1..length, clears on every phase change; no wrap for any length up to 2^CNT_W-1.
REQ-023 ch_sel stable for the whole TX..HOLD span of a channel; changes only at channel boundaries.
REQ-024 abort=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no ch_done/seq_done; abort has priority over start in the same cycle.
REQ-025 Input changes during a sequence have no effect until the next start.

Reset
REQ-026 reset=0 at a clock edge: state IDLE, counter 0, busy, tx_pulse, acq_win, ch_done, seq_done 0, ch_sel 0, latched config 0.
REQ-027 Reset mid-sequence behaves as abort; reset has priority over abort and start.

Configuration
REQ-028 Macro PULSE_SEQ_LOOP_EN: when defined, after the last channel's HOLD the block emits seq_done and restarts at the lowest latched mask bit without passing IDLE, repeating until abort or reset.
REQ-029 Without PULSE_SEQ_LOOP_EN the block performs one sequence per start and returns to IDLE (REQ-021).

Verification
REQ-030 mask=4'b0101, tx=3, delay=2, win=5, hold=1, start -> ch_sel=0 then 2; tx_pulse 3 cycles, acq_win 5 cycles each; seq_done once, 23 cycles after start.
REQ-031 mask=0, start -> busy stays 0, no outputs asserted.
REQ-032 mask=4'b0001, tx=0, delay=0, win=4, hold=0 -> no tx_pulse; acq_win high 4 cycles beginning the cycle after start.
REQ-033 abort during ACQ of channel 1 -> next cycle busy=0, acq_win=0, no ch_done/seq_done; a subsequent start runs normally.
REQ-034 win_len=16383 -> acq_win high exactly 16383 cycles, no counter wrap.
REQ-035 With PULSE_SEQ_LOOP_EN, mask=4'b0011 -> ch_sel 0,1,0,1..., seq_done every pass; abort -> IDLE.
